// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver: sync byte, FSM state
// encoding and the running-checksum helper.
package serial_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  // Checksum is an 8-bit wrapping sum of LEN and every payload byte.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/serial_frame_buf.sv
// Payload store for serial_frame_rx: one synchronous write port and one
// asynchronous read port. Depth is rounded up to a power of two so the
// address width exactly matches the array.
module serial_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];

  // Capture one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: parses SYNC(0xA5), LEN, payload, CHK from a byte
// stream, buffers the payload and replays it on a valid/ready output once
// the checksum matches.
// Optional feature: define SERIAL_FRAME_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CLKS cycles without an input byte while in LEN, PAYLOAD or CHK.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int         BUF_AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  // Reject illegal parameterisations at elaboration time.
  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_param
    $error("serial_frame_rx: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 2");
  end

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       busy_q;

  logic       buf_we_s;
  logic [7:0] rd_addr_s;
  logic [7:0] rd_data_s;
  logic       timeout_s;

`ifdef SERIAL_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CLKS) + 1;
  logic [CNT_W-1:0] tmo_cnt_q;

  // Count idle cycles while a frame is being collected; any input byte restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (in_valid ||
                 !(state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign timeout_s = (tmo_cnt_q == CNT_W'(TIMEOUT_CLKS - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // While draining, look ahead to the byte after the one being presented;
  // otherwise address 0 so a checksum match can load the first byte.
  assign rd_addr_s = (state_q == ST_DRAIN) ? (idx_q + 8'd1) : 8'd0;

  serial_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we_s),
    .waddr_i (idx_q[BUF_AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_addr_s[BUF_AW-1:0]),
    .rdata_o (rd_data_s)
  );

  // Frame parser and output sequencer next-state logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    buf_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (in_valid) begin
          if ((in_data == 8'h00) || (in_data > MAX_LEN8)) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            len_d   = in_data;
            sum_d   = in_data;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end else if (timeout_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          buf_we_s = 1'b1;
          sum_d    = chk_add(sum_q, in_data);
          if (idx_q == (len_q - 8'd1)) begin
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (timeout_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (in_valid) begin
          if (in_data == sum_q) begin
            state_d     = ST_DRAIN;
            frame_ok_d  = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = rd_data_s;
            out_last_d  = (len_q == 8'd1);
            idx_d       = 8'd0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (timeout_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_DRAIN: begin
        overrun_d = in_valid;
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_q + 8'd1;
            out_data_d = rd_data_s;
            out_last_d = ((idx_q + 8'd2) == len_q);
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset abandons any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      sum_q       <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: a frame-level model predicts the
// payload bytes and status pulses, a monitor compares every output cycle,
// and directed checks pin the cases with literal expectations.
module tb_serial_frame_rx;

  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_CLKS = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  serial_frame_rx #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int ok_seen = 0, err_seen = 0, ovr_seen = 0;
  int ok_exp  = 0, err_exp  = 0, ovr_exp  = 0;
  logic [8:0] exp_q[$];   // {last, data}
  logic [7:0] stim_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Frame-level model: scan the byte list, predict pulses and delivered payload.
  task automatic model_scan();
    int i = 0;
    int n = stim_q.size();
    int len;
    int sum;
    while (i < n) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= n) break;
      len = int'(stim_q[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        err_exp++;
        i += 2;
        continue;
      end
      if (i + 2 + len >= n) break;
      sum = len;
      for (int j = 0; j < len; j++) sum += int'(stim_q[i+2+j]);
      if ((sum % 256) == int'(stim_q[i+2+len])) begin
        ok_exp++;
        for (int j = 0; j < len; j++) exp_q.push_back({(j == len - 1), stim_q[i+2+j]});
      end else begin
        err_exp++;
      end
      i += 3 + len;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_stream();
    model_scan();
    foreach (stim_q[i]) send(stim_q[i]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      fails++;
      $display("FAIL %s_idle: busy=1 after 200 cycles, required 0", name);
    end
    check({name, "_valid_low"}, out_valid, 1'b0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_ok_count"},  ok_seen,  ok_exp);
    check({name, "_err_count"}, err_seen, err_exp);
    check({name, "_ovr_count"}, ovr_seen, ovr_exp);
    check({name, "_pending"},   exp_q.size(), 0);
  endtask

  // Output monitor: pulse counting, handshake data/last against the model, hold-while-stalled.
  always @(negedge clk) begin
    logic [8:0] e;
    if (frame_ok)  ok_seen++;
    if (frame_err) err_seen++;
    if (overrun)   ovr_seen++;
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data",  out_data,  prev_data);
      check("hold_last",  out_last,  prev_last);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: out_valid=1 data=0x%02h, required no output", out_data);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_last", out_last, e[8]);
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_err;
    int err_before;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_frame_ok",  frame_ok,  1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun",   overrun,   1'b0);
    check("rst_busy",      busy,      1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Good frame preceded by noise
    stim_q = '{8'h00, 8'h11, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    run_stream();
    @(negedge clk);
    check("t1_frame_ok", frame_ok, 1'b1);
    check("t1_first",    out_data, 8'h11);
    wait_idle("t1");
    check("t1_ok_lit", ok_seen, 1);
    check_counts("t1");

    // Bad checksum
    stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    run_stream();
    @(negedge clk);
    check("t2_frame_err", frame_err, 1'b1);
    check("t2_valid",     out_valid, 1'b0);
    wait_idle("t2");
    check_counts("t2");

    // Illegal lengths, then a one-byte frame
    stim_q = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    run_stream();
    @(negedge clk);
    check("t3_frame_ok", frame_ok, 1'b1);
    check("t3_data",     out_data, 8'h7E);
    check("t3_last",     out_last, 1'b1);
    wait_idle("t3");
    check("t3_err_lit", err_seen, 3);
    check_counts("t3");

    // Backpressure plus an injected byte during drain
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    run_stream();
    @(negedge clk);
    check("t4_valid", out_valid, 1'b1);
    check("t4_data",  out_data,  8'h11);
    repeat (3) @(posedge clk);
    #1;
    send(8'h55);
    ovr_exp++;
    @(negedge clk);
    check("t4_overrun", overrun, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_still_held", out_data, 8'h11);
    out_ready = 1'b1;
    wait_idle("t4");
    check_counts("t4");

    // Inter-byte silence
    send(8'hA5);
    send(8'h03);
    send(8'h11);
    t_err = -1;
    for (int k = 1; k <= 2100; k++) begin
      @(posedge clk);
      #1;
      if (frame_err && t_err < 0) t_err = k;
    end
`ifdef SERIAL_FRAME_TIMEOUT_EN
    err_exp++;
    checks++;
    if (t_err < TIMEOUT_CLKS - 1 || t_err > TIMEOUT_CLKS + 1) begin
      fails++;
      $display("FAIL t5_timeout: frame_err after %0d cycles, required %0d +/-1", t_err, TIMEOUT_CLKS);
    end
    check("t5_busy", busy, 1'b0);
`else
    check("t5_no_timeout", t_err, -1);
    check("t5_busy", busy, 1'b1);
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_counts("t5");

    // Reset mid-frame, then a full frame
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    err_before = err_seen;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid",     out_valid, 1'b0);
    check("t6_last",      out_last,  1'b0);
    check("t6_ok",        frame_ok,  1'b0);
    check("t6_err",       frame_err, 1'b0);
    check("t6_overrun",   overrun,   1'b0);
    check("t6_busy",      busy,      1'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_err", err_seen, err_before);
    stim_q = '{8'hA5, 8'h02, 8'h40, 8'h50, 8'h92};
    run_stream();
    @(negedge clk);
    check("t6_frame_ok", frame_ok, 1'b1);
    check("t6_first",    out_data, 8'h40);
    wait_idle("t6");
    check_counts("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2000, inter-byte timeout in clk cycles.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port in_valid  input  1  single-cycle strobe qualifying in_data; no backpressure.
REQ-007 SHALL have port out_data  output  8  payload byte.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid and out_ready are both high.
REQ-010 SHALL have port out_last  output  1  high with the final payload byte.
REQ-011 SHALL have port frame_ok  output  1  one-cycle pulse: frame passed checks.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: frame discarded.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse: input byte dropped during DRAIN.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL define the frame format as: SYNC 0xA5, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload) mod 256.
REQ-016 SHALL implement states IDLE, LEN, PAYLOAD, CHK and DRAIN.
REQ-017 IDLE SHALL discard all bytes except 0xA5, which moves the machine to LEN.
REQ-018 In LEN, a byte of 0 or greater than MAX_LEN SHALL pulse frame_err the next cycle and return the machine to IDLE; any other byte SHALL be stored, seed the running sum and move the machine to PAYLOAD.
REQ-019 PAYLOAD SHALL write each byte into the buffer at an index starting at 0 and add it to the 8-bit wrapping sum; after byte LEN it SHALL move to CHK.
REQ-020 In CHK, a matching byte SHALL move the machine to DRAIN and, on the next cycle, pulse frame_ok and raise out_valid with buffer byte 0.
REQ-021 In CHK, a mismatching byte SHALL pulse frame_err on the next cycle, return the machine to IDLE and never raise out_valid.
REQ-022 DRAIN SHALL present buffer bytes in order, hold out_data and out_valid stable while out_ready is low, and raise out_last only on byte LEN-1.
REQ-023 After the handshake of the last byte, the machine SHALL be in IDLE on the next cycle with out_valid low.
REQ-024 Any in_valid in DRAIN, including the cycle of the last handshake, SHALL drop the byte and pulse overrun on the next cycle.
REQ-025 Frame byte 0xA5 appearing in LEN, PAYLOAD or CHK SHALL be treated as data, with no resynchronisation.

Reset
REQ-026 While rst is high, the machine SHALL go to IDLE, clear the index, sum and timeout counter, and drive out_valid, out_last, frame_ok, frame_err, overrun and busy to 0 on the next edge.
REQ-027 Reset mid-frame or mid-DRAIN SHALL abandon the frame without a frame_err pulse; buffer contents are don't-care.

Configuration
REQ-028 With SERIAL_FRAME_TIMEOUT_EN defined, a counter SHALL run in LEN, PAYLOAD and CHK, clearing on every in_valid.
REQ-029 With SERIAL_FRAME_TIMEOUT_EN defined, reaching TIMEOUT_CLKS-1 without in_valid SHALL pulse frame_err and return the machine to IDLE.
REQ-030 Without SERIAL_FRAME_TIMEOUT_EN, no counter SHALL exist, the machine SHALL wait indefinitely, and TIMEOUT_CLKS SHALL be unused.

Structure
REQ-031 A shared package serial_frame_pkg SHALL hold the SYNC_BYTE constant (0xA5) and the state enum typedef.
REQ-032 The payload store SHALL be sub-module serial_frame_buf (MAX_LEN x 8, one write port, one asynchronous read port).

Verification
REQ-033 Bench SHALL cover: bytes 0x00, 0x11, A5 03 11 22 33 69 with out_ready=1 -> frame_ok once; outputs 11, 22, 33, out_last on 33; busy low afterwards.
REQ-034 Bench SHALL cover: A5 03 11 22 33 68 -> frame_err one cycle after 0x68; out_valid never high.
REQ-035 Bench SHALL cover: A5 00 and A5 11 (MAX_LEN=16) -> frame_err for each; next A5 01 7E 7F delivers 7E with out_last.
REQ-036 Bench SHALL cover: valid frame with out_ready low for 10 cycles after out_valid rises -> out_data=0x11 held stable; a byte injected mid-DRAIN pulses overrun and is not delivered.
REQ-037 Bench SHALL cover, with SERIAL_FRAME_TIMEOUT_EN and TIMEOUT_CLKS=2000: A5 03 11 then silence -> frame_err 2000 cycles after the last in_valid (+/-1); without the macro, no frame_err.
REQ-038 Bench SHALL cover: rst pulsed after A5 02 11 -> all outputs 0, no frame_err; a subsequent full frame is received correctly.
